// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: head-of-FIFO handshake between receiver and consumer.
// master drives data/valid, slave (consumer) drives ready.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (opt. parity) feeding a receive FIFO.
// Define UART_RX_FIFO_BREAK_DETECT_EN to add the rx_break output.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        resetb,
    input  logic                        ser_rx,
    uart_rx_fifo_if.master              rx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow,
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
    output logic                        rx_break,
`endif
    input  logic                        err_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 16;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] TOP  = IW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
    localparam bit HAS_PAR = (PARITY != 0);
    localparam bit ODD     = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    logic                 sync1_q, sync2_q, rx_s;
    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_bad_q;

    logic                 tick, stop_smp, push_w;
    logic                 par_evt, ferr_evt, ovf_evt;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          count_q;
    logic                 full, pop, wr_en;
    logic                 frame_q, parity_q, ovf_q;

    assign rx_s     = sync2_q;
    assign tick     = (cnt_q == LAST);
    assign stop_smp = (state_q == S_STOP) && !stop_bad_q && tick;
    assign push_w   = stop_smp && rx_s;
    assign par_evt  = (state_q == S_PARITY) && tick &&
                      ((^shift_q ^ rx_s) != ODD);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ser_rx;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM: start validated at mid-bit, then one sample per bit period.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            stop_bad_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_q      <= '0;
                    bit_q      <= '0;
                    stop_bad_q <= 1'b0;
                    if (!rx_s) state_q <= S_START;
                end
                S_START: begin
                    if (cnt_q == HALF) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == TOP) begin
                            bit_q   <= '0;
                            state_q <= HAS_PAR ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (stop_bad_q) begin
                        if (rx_s) begin
                            stop_bad_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end else if (tick) begin
                        cnt_q <= '0;
                        if (rx_s) state_q <= S_IDLE;
                        else      stop_bad_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_BREAK_DETECT_EN
    localparam int BRK_BITS = DATA_BITS + (HAS_PAR ? 1 : 0) + 2;
    localparam logic [23:0] BRK_CYC = 24'(BRK_BITS * CLKS_PER_BIT);

    logic [23:0] low_q;
    logic        brk_q;

    // Measure the current low run; a full frame's worth of low is a break.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            low_q <= '0;
            brk_q <= 1'b0;
        end else if (rx_s) begin
            low_q <= '0;
            brk_q <= 1'b0;
        end else if (low_q != BRK_CYC) begin
            low_q <= low_q + 1'b1;
        end else begin
            brk_q <= 1'b1;
        end
    end

    assign rx_break = brk_q;
    // Framing error is deferred until the line recovers, so a break can veto it.
    assign ferr_evt = (state_q == S_STOP) && stop_bad_q && rx_s && !brk_q;
`else
    assign ferr_evt = stop_smp && !rx_s;
`endif

    assign full    = (count_q == FULL);
    assign pop     = (count_q != '0) && rx.rx_ready;
    assign wr_en   = push_w && (!full || pop);
    assign ovf_evt = push_w && full && !pop;

    // Storage has no reset; empty FIFO masks the head word to zero.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_q] <= shift_q;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            frame_q  <= 1'b0;
            parity_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            frame_q  <= (frame_q  & ~err_clear) | ferr_evt;
            parity_q <= (parity_q & ~err_clear) | par_evt;
            ovf_q    <= (ovf_q    & ~err_clear) | ovf_evt;
        end
    end

    assign rx.rx_valid = (count_q != '0);
    assign rx.rx_data  = (count_q != '0) ? mem_q[rd_q] : '0;
    assign fifo_count  = count_q;
    assign frame_err   = frame_q;
    assign parity_err  = parity_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed + randomized bench for uart_rx_fifo.
// dut: no parity; dut_p: even parity. Both CLKS_PER_BIT=8, depth 4.
module tb_uart_rx_fifo;
    localparam int CPB   = 8;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetb, ser_rx, ser_rx_p, err_clear;
    logic [2:0] fifo_count, fifo_count_p;
    logic       frame_err, parity_err, overflow;
    logic       frame_err_p, parity_err_p, overflow_p;
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
    logic       rx_break, rx_break_p;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo_if #(.DATA_BITS(DB)) bus ();
    uart_rx_fifo_if #(.DATA_BITS(DB)) bus_p ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DB),
        .PARITY(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .resetb(resetb), .ser_rx(ser_rx), .rx(bus),
        .fifo_count(fifo_count), .frame_err(frame_err),
        .parity_err(parity_err), .overflow(overflow),
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
        .rx_break(rx_break),
`endif
        .err_clear(err_clear)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DB),
        .PARITY(1), .FIFO_DEPTH(DEPTH)
    ) dut_p (
        .clock(clock), .resetb(resetb), .ser_rx(ser_rx_p), .rx(bus_p),
        .fifo_count(fifo_count_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .overflow(overflow_p),
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
        .rx_break(rx_break_p),
`endif
        .err_clear(err_clear)
    );

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input bit p, input logic v);
        if (p) ser_rx_p = v;
        else   ser_rx   = v;
    endtask

    // Serial frame: start, 8 data LSB first, optional parity, stop.
    // cnt_pre: FIFO count one cycle before the end of the stop bit.
    task automatic send(input bit p, input logic [7:0] d,
                        input logic par, input logic stop,
                        input bit pop_at_stop, output int cnt_pre);
        @(negedge clock);
        drive(p, 1'b0);
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            drive(p, d[i]);
            hold(CPB);
        end
        if (p) begin
            drive(p, par);
            hold(CPB);
        end
        drive(p, stop);
        hold(CPB - 1);
        cnt_pre = p ? int'(fifo_count_p) : int'(fifo_count);
        if (pop_at_stop) bus.rx_ready = 1'b1;
        hold(1);
        bus.rx_ready = 1'b0;
        drive(p, 1'b1);
    endtask

    task automatic pop_one(output logic v, output logic [7:0] d);
        v = bus.rx_valid;
        d = bus.rx_data;
        bus.rx_ready = 1'b1;
        hold(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        hold(1);
        err_clear = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        ser_rx = 1'b1;
        ser_rx_p = 1'b1;
        err_clear = 1'b0;
        bus.rx_ready = 1'b0;
        bus_p.rx_ready = 1'b0;
        hold(3);
        checks++;
        if (bus.rx_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b count=%0d want 0/0",
                     bus.rx_valid, fifo_count);
        end
        resetb = 1'b1;
        hold(2);
        checks++;
        if ({bus.rx_valid, bus.rx_data, fifo_count} !== 12'h000) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h count=%0d want 0",
                     bus.rx_valid, bus.rx_data, fifo_count);
        end
        checks++;
        if ({frame_err, parity_err, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {frame_err, parity_err, overflow});
        end
    endtask

    task automatic test_single();
        int pre;
        logic v;
        logic [7:0] d;
        send(1'b0, 8'h37, 1'b0, 1'b1, 1'b0, pre);
        checks++;
        if (pre !== 0 || fifo_count !== 3'd1 || bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: pre=%0d count=%0d valid=%b want 0/1/1",
                     pre, fifo_count, bus.rx_valid);
        end
        checks++;
        if (bus.rx_data !== 8'h37) begin
            errors++;
            $display("FAIL single_data: got %h want 37", bus.rx_data);
        end
        checks++;
        if ({frame_err, parity_err, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL single_flags: got %b want 000",
                     {frame_err, parity_err, overflow});
        end
        hold(5);
        checks++;
        if (bus.rx_data !== 8'h37 || bus.rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_stable: data=%h valid=%b want 37/1",
                     bus.rx_data, bus.rx_valid);
        end
        pop_one(v, d);
        checks++;
        if (fifo_count !== 3'd0 || bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: count=%0d valid=%b want 0/0",
                     fifo_count, bus.rx_valid);
        end
    endtask

    task automatic test_parity();
        int pre;
        // 0x37 has five ones, so even parity needs 1; send 0.
        send(1'b1, 8'h37, 1'b0, 1'b1, 1'b0, pre);
        checks++;
        if (bus_p.rx_data !== 8'h37 || fifo_count_p !== 3'd1) begin
            errors++;
            $display("FAIL parity_push: data=%h count=%0d want 37/1",
                     bus_p.rx_data, fifo_count_p);
        end
        checks++;
        if (parity_err_p !== 1'b1 || frame_err_p !== 1'b0) begin
            errors++;
            $display("FAIL parity_flag: perr=%b ferr=%b want 1/0",
                     parity_err_p, frame_err_p);
        end
        clear_errs();
        checks++;
        if (parity_err_p !== 1'b0) begin
            errors++;
            $display("FAIL parity_clear: got %b want 0", parity_err_p);
        end
        // 0xA5 has four ones: even parity bit 0 is correct.
        send(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, pre);
        checks++;
        if (parity_err_p !== 1'b0 || fifo_count_p !== 3'd2) begin
            errors++;
            $display("FAIL parity_good: perr=%b count=%0d want 0/2",
                     parity_err_p, fifo_count_p);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        logic ovf;
        int pre;
        logic v;
        logic [7:0] d;
        for (int pass = 0; pass < 2; pass++) begin
            ovf = 1'b0;
            for (int i = 1; i <= 5; i++) begin
                bit pp;
                pp = (pass == 1) && (i == 5);
                send(1'b0, 8'(i), 1'b0, 1'b1, pp, pre);
                if (pp) void'(q.pop_front());
                if (q.size() < DEPTH) q.push_back(8'(i));
                else ovf = 1'b1;
            end
            checks++;
            if (fifo_count !== 3'(q.size()) || overflow !== ovf) begin
                errors++;
                $display("FAIL ovf_state%0d: count=%0d ovf=%b want %0d/%b",
                         pass, fifo_count, overflow, q.size(), ovf);
            end
            while (q.size() > 0) begin
                pop_one(v, d);
                checks++;
                if (v !== 1'b1 || d !== q[0]) begin
                    errors++;
                    $display("FAIL ovf_read%0d: valid=%b data=%h want 1/%h",
                             pass, v, d, q[0]);
                end
                void'(q.pop_front());
            end
            clear_errs();
        end
    endtask

    task automatic test_glitch_frame();
        int pre;
        @(negedge clock);
        ser_rx = 1'b0;
        hold(3);
        ser_rx = 1'b1;
        hold(30);
        checks++;
        if (fifo_count !== 3'd0 || {frame_err, parity_err, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL glitch: count=%0d flags=%b want 0/000",
                     fifo_count, {frame_err, parity_err, overflow});
        end
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, pre);
        hold(10);
        checks++;
        if (frame_err !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bad_stop: ferr=%b count=%0d want 1/0",
                     frame_err, fifo_count);
        end
        clear_errs();
    endtask

    task automatic test_mid_reset();
        int pre;
        logic [7:0] a;
        logic v;
        logic [7:0] d;
        a = 8'hA5;
        @(negedge clock);
        ser_rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            ser_rx = a[i];
            hold(CPB);
        end
        resetb = 1'b0;
        #1;
        checks++;
        if (bus.rx_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d want 0/0",
                     bus.rx_valid, fifo_count);
        end
        ser_rx = 1'b1;
        hold(3);
        resetb = 1'b1;
        hold(20);
        send(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, pre);
        checks++;
        if (fifo_count !== 3'd1 || bus.rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL mid_reset_rx: count=%0d data=%h want 1/5a",
                     fifo_count, bus.rx_data);
        end
        checks++;
        if ({frame_err, parity_err, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_flags: got %b want 000",
                     {frame_err, parity_err, overflow});
        end
        pop_one(v, d);
    endtask

    task automatic test_break();
        @(negedge clock);
        ser_rx = 1'b0;
        hold(12 * CPB);
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
        checks++;
        if (rx_break !== 1'b1 || frame_err !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL break_on: brk=%b ferr=%b count=%0d want 1/0/0",
                     rx_break, frame_err, fifo_count);
        end
        ser_rx = 1'b1;
        hold(5);
        checks++;
        if (rx_break !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL break_off: brk=%b ferr=%b want 0/0",
                     rx_break, frame_err);
        end
`else
        ser_rx = 1'b1;
        hold(5);
        checks++;
        if (frame_err !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL break_frame: ferr=%b count=%0d want 1/0",
                     frame_err, fifo_count);
        end
`endif
        clear_errs();
    endtask

    // Random words and random draining against a queue model.
    task automatic test_random();
        logic [7:0] q[$];
        logic ovf;
        int pre, k;
        logic v;
        logic [7:0] w, d;
        bit pp;
        ovf = 1'b0;
        for (int n = 0; n < 24; n++) begin
            w  = 8'($urandom);
            pp = ($urandom_range(3, 0) == 0);
            send(1'b0, w, 1'b0, 1'b1, pp, pre);
            if (pp && q.size() > 0) void'(q.pop_front());
            if (q.size() < DEPTH) q.push_back(w);
            else ovf = 1'b1;
            checks++;
            if (fifo_count !== 3'(q.size()) || overflow !== ovf) begin
                errors++;
                $display("FAIL rand_state%0d: count=%0d ovf=%b want %0d/%b",
                         n, fifo_count, overflow, q.size(), ovf);
            end
            k = $urandom_range(q.size(), 0);
            for (int j = 0; j < k; j++) begin
                pop_one(v, d);
                checks++;
                if (v !== 1'b1 || d !== q[0]) begin
                    errors++;
                    $display("FAIL rand_read%0d: valid=%b data=%h want 1/%h",
                             n, v, d, q[0]);
                end
                void'(q.pop_front());
            end
            if ($urandom_range(3, 0) == 0) begin
                clear_errs();
                ovf = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_overflow();
        test_glitch_frame();
        test_mid_reset();
        test_break();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
